// File: rtl/dma_pkg.sv
// Definitions shared by the DMA engines and controller_v2: bus widths and
// the read-engine state encoding.
package dma_pkg;

   localparam int unsigned DMA_ADDR_WIDTH = 27;
   localparam int unsigned DMA_DATA_WIDTH = 512;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      BUSY = 2'd2
   } dma_state_t;

endpackage

// File: rtl/dma_read_engine.sv
// Read-side responder for the dma_engineer_* interface. It takes one
// request, bursts reads to memory with a bounded number in flight, and
// streams the returned words with an end-of-packet marker.
module dma_read_engine
   import dma_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = DMA_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH      = DMA_DATA_WIDTH,
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dma_engineer_req,
   output logic                  dma_engineer_ack,
   input  logic [ADDR_WIDTH-1:0] dma_engineer_start_addr,
   input  logic [ADDR_WIDTH-1:0] dma_engineer_length,
   output logic [DATA_WIDTH-1:0] dma_engineer_dout,
   output logic                  dma_engineer_dout_en,
   output logic                  dma_engineer_dout_eop,
   output logic                  mem_rd_req,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic                  mem_rd_gnt,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   input  logic                  mem_rd_valid
);

   localparam int unsigned           OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [OUT_W-1:0]      OUT_MAX = OUT_W'(MAX_OUTSTANDING);
   localparam logic [OUT_W-1:0]      OUT_ONE = OUT_W'(1);
   localparam logic [ADDR_WIDTH-1:0] A_ONE   = ADDR_WIDTH'(1);

   dma_state_t            state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] len_q;
   logic [ADDR_WIDTH-1:0] issued;
   logic [ADDR_WIDTH-1:0] returned;
   logic [OUT_W-1:0]      outstanding;
   logic                  rd_accept;

   // Request side depends on registered state only, so gnt never loops back into req.
   always_comb begin
      mem_rd_req  = (state == BUSY) && (issued < len_q) && (outstanding < OUT_MAX);
      mem_rd_addr = addr_q + issued;
      rd_accept   = mem_rd_req && mem_rd_gnt;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state                 <= IDLE;
         addr_q                <= '0;
         len_q                 <= '0;
         issued                <= '0;
         returned              <= '0;
         outstanding           <= '0;
         dma_engineer_ack      <= 1'b0;
         dma_engineer_dout     <= '0;
         dma_engineer_dout_en  <= 1'b0;
         dma_engineer_dout_eop <= 1'b0;
      end else begin
         dma_engineer_ack      <= 1'b0;
         dma_engineer_dout_en  <= 1'b0;
         dma_engineer_dout_eop <= 1'b0;
         case (state)
            IDLE: begin
               if (dma_engineer_req) begin
                  addr_q           <= dma_engineer_start_addr;
                  len_q            <= dma_engineer_length;
                  issued           <= '0;
                  returned         <= '0;
                  outstanding      <= '0;
                  dma_engineer_ack <= 1'b1;
                  state            <= ACK;
               end
            end
            ACK: begin
               state <= (len_q == '0) ? IDLE : BUSY;
            end
            BUSY: begin
               if (rd_accept)
                  issued <= issued + A_ONE;
               if (rd_accept && !mem_rd_valid)
                  outstanding <= outstanding + OUT_ONE;
               else if (!rd_accept && mem_rd_valid)
                  outstanding <= outstanding - OUT_ONE;
               if (mem_rd_valid) begin
                  dma_engineer_dout    <= mem_rd_data;
                  dma_engineer_dout_en <= 1'b1;
                  returned             <= returned + A_ONE;
                  // Last word: the eop edge is also the return to IDLE.
                  if (returned == len_q - A_ONE) begin
                     dma_engineer_dout_eop <= 1'b1;
                     state                 <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_read_engine.sv
// Scoreboard bench for dma_read_engine: a latency-modelled memory responder,
// an expected-word queue checked on every dout_en, and per-scenario tasks.
module tb_dma_read_engine;

   localparam int unsigned AW = 27;
   localparam int unsigned DW = 512;

   typedef struct {
      logic [DW-1:0] data;
      logic          eop;
   } exp_ent_t;

   typedef struct {
      int unsigned   due;
      logic [DW-1:0] data;
   } mem_ent_t;

   logic          clk;
   logic          rst;
   logic          dma_engineer_req;
   logic          dma_engineer_ack;
   logic [AW-1:0] dma_engineer_start_addr;
   logic [AW-1:0] dma_engineer_length;
   logic [DW-1:0] dma_engineer_dout;
   logic          dma_engineer_dout_en;
   logic          dma_engineer_dout_eop;
   logic          mem_rd_req;
   logic [AW-1:0] mem_rd_addr;
   logic          mem_rd_gnt;
   logic [DW-1:0] mem_rd_data;
   logic          mem_rd_valid;

   int unsigned   checks = 0;
   int unsigned   errors = 0;
   int unsigned   cyc = 0;
   int unsigned   lat = 3;
   bit            hold_valid = 0;
   bit            gnt_rand = 0;
   bit            valid_rand = 0;
   bit            mon_en = 0;
   int unsigned   n_ack, n_dout, n_eop, n_grant, max_out;

   exp_ent_t      exp_q[$];
   logic [AW-1:0] exp_addr_q[$];
   mem_ent_t      mem_q[$];

   dma_read_engine #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .MAX_OUTSTANDING(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .dma_engineer_req(dma_engineer_req),
      .dma_engineer_ack(dma_engineer_ack),
      .dma_engineer_start_addr(dma_engineer_start_addr),
      .dma_engineer_length(dma_engineer_length),
      .dma_engineer_dout(dma_engineer_dout),
      .dma_engineer_dout_en(dma_engineer_dout_en),
      .dma_engineer_dout_eop(dma_engineer_dout_eop),
      .mem_rd_req(mem_rd_req),
      .mem_rd_addr(mem_rd_addr),
      .mem_rd_gnt(mem_rd_gnt),
      .mem_rd_data(mem_rd_data),
      .mem_rd_valid(mem_rd_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
      logic [31:0] w;
      w = {5'b0, a} ^ 32'hC3A5_0000;
      return {16{w}};
   endfunction

   // Memory responder: in-order returns after 'lat' cycles, optional random gnt/valid.
   initial begin : mem_model
      mem_ent_t      m;
      logic [AW-1:0] ea;
      bit            vld;
      mem_rd_gnt   = 1'b0;
      mem_rd_valid = 1'b0;
      mem_rd_data  = '0;
      forever begin
         @(negedge clk);
         vld = 0;
         if (mem_q.size() > 0 && mem_q[0].due <= cyc && !hold_valid &&
             (!valid_rand || $urandom_range(1, 0) == 1))
            vld = 1;
         mem_rd_valid = vld;
         mem_rd_data  = vld ? mem_q[0].data : '0;
         if (vld) void'(mem_q.pop_front());
         mem_rd_gnt = gnt_rand ? ($urandom_range(1, 0) == 1) : 1'b1;
         #1;
         if (mem_rd_req === 1'b1 && mem_rd_gnt === 1'b1) begin
            n_grant++;
            checks++;
            if (exp_addr_q.size() == 0) begin
               errors++;
               $display("FAIL rd_addr_extra: unexpected grant at addr %h", mem_rd_addr);
            end else begin
               ea = exp_addr_q.pop_front();
               if (mem_rd_addr !== ea) begin
                  errors++;
                  $display("FAIL rd_addr: got %h expected %h", mem_rd_addr, ea);
               end
            end
            m.due  = cyc + lat;
            m.data = word_of(mem_rd_addr);
            mem_q.push_back(m);
            if (mem_q.size() > max_out) max_out = mem_q.size();
         end
      end
   end

   // Output monitor / scoreboard consumer.
   initial begin : monitor
      exp_ent_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (dma_engineer_ack === 1'b1) n_ack++;
            if (dma_engineer_dout_en === 1'b1) begin
               n_dout++;
               if (dma_engineer_dout_eop === 1'b1) n_eop++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL dout_extra: unexpected dout %h", dma_engineer_dout[31:0]);
               end else begin
                  e = exp_q.pop_front();
                  checks++;
                  if (dma_engineer_dout !== e.data) begin
                     errors++;
                     $display("FAIL dout_data: got %h expected %h", dma_engineer_dout, e.data);
                  end
                  checks++;
                  if (dma_engineer_dout_eop !== e.eop) begin
                     errors++;
                     $display("FAIL dout_eop: got %b expected %b", dma_engineer_dout_eop, e.eop);
                  end
               end
            end else begin
               checks++;
               if (dma_engineer_dout_eop !== 1'b0) begin
                  errors++;
                  $display("FAIL eop_without_en: eop=%b expected 0", dma_engineer_dout_eop);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_stats();
      n_ack = 0; n_dout = 0; n_eop = 0; n_grant = 0; max_out = 0;
   endtask

   task automatic push_stream(input logic [AW-1:0] s, input int unsigned len);
      exp_ent_t      e;
      logic [AW-1:0] a;
      for (int unsigned i = 0; i < len; i++) begin
         a      = s + AW'(i);
         e.data = word_of(a);
         e.eop  = (i == len - 1);
         exp_q.push_back(e);
         exp_addr_q.push_back(a);
      end
   endtask

   // Called just after a negedge; returns in the ack cycle (or one later with hold_extra).
   task automatic do_req(input logic [AW-1:0] s, input logic [AW-1:0] l, input bit hold_extra);
      dma_engineer_start_addr = s;
      dma_engineer_length     = l;
      dma_engineer_req        = 1'b1;
      @(negedge clk);
      checks++;
      if (dma_engineer_ack !== 1'b1) begin
         errors++;
         $display("FAIL ack_latency: ack=%b expected 1 one cycle after req", dma_engineer_ack);
      end
      if (hold_extra) @(negedge clk);
      dma_engineer_req = 1'b0;
   endtask

   task automatic wait_done(input int unsigned budget);
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL stream_timeout: %0d words missing after %0d cycles expected 0", exp_q.size(), n);
         exp_q.delete();
         exp_addr_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_cnt(input string name, input int unsigned got, input int unsigned want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      dma_engineer_req = 1'b0;
      dma_engineer_start_addr = '0;
      dma_engineer_length = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({dma_engineer_ack, dma_engineer_dout_en, dma_engineer_dout_eop, mem_rd_req} !== 4'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ack/en/eop/req=%b expected 0000",
                  {dma_engineer_ack, dma_engineer_dout_en, dma_engineer_dout_eop, mem_rd_req});
      end
      checks++;
      if (dma_engineer_dout !== '0) begin
         errors++;
         $display("FAIL reset_dout: got %h expected 0", dma_engineer_dout[31:0]);
      end
      checks++;
      if (mem_rd_addr !== '0) begin
         errors++;
         $display("FAIL reset_addr: got %h expected 0", mem_rd_addr);
      end
      rst = 1'b1;
      @(negedge clk);
      mon_en = 1;
   endtask

   task automatic test_basic();
      clear_stats();
      lat = 3;
      push_stream(27'h100, 4);
      do_req(27'h100, 27'd4, 0);
      wait_done(200);
      check_cnt("basic_ack", n_ack, 1);
      check_cnt("basic_dout", n_dout, 4);
      check_cnt("basic_eop", n_eop, 1);
      check_cnt("basic_grants", n_grant, 4);
   endtask

   task automatic test_outstanding();
      clear_stats();
      lat = 3;
      hold_valid = 1;
      push_stream(27'h1000, 20);
      do_req(27'h1000, 27'd20, 0);
      repeat (30) @(negedge clk);
      check_cnt("limit_grants", n_grant, 8);
      check_cnt("limit_req_low", 32'(mem_rd_req), 0);
      check_cnt("limit_no_dout", n_dout, 0);
      hold_valid = 0;
      wait_done(300);
      check_cnt("limit_dout", n_dout, 20);
      check_cnt("limit_eop", n_eop, 1);
      check_cnt("limit_max_out", max_out, 8);
   endtask

   task automatic test_random_stalls();
      clear_stats();
      lat = 2;
      gnt_rand = 1;
      valid_rand = 1;
      push_stream(27'h2000, 64);
      do_req(27'h2000, 27'd64, 0);
      wait_done(2000);
      gnt_rand = 0;
      valid_rand = 0;
      check_cnt("rand_dout", n_dout, 64);
      check_cnt("rand_grants", n_grant, 64);
      checks++;
      if (max_out > 8) begin
         errors++;
         $display("FAIL rand_max_out: got %0d expected <= 8", max_out);
      end
   endtask

   task automatic test_len0_len1();
      clear_stats();
      lat = 1;
      do_req(27'h700, 27'd0, 0);
      @(negedge clk);
      check_cnt("len0_req_low", 32'(mem_rd_req), 0);
      push_stream(27'h800, 1);
      do_req(27'h800, 27'd1, 0);
      wait_done(100);
      check_cnt("len01_ack", n_ack, 2);
      check_cnt("len01_grants", n_grant, 1);
      check_cnt("len1_dout", n_dout, 1);
      check_cnt("len1_eop", n_eop, 1);
   endtask

   task automatic test_wrap();
      logic [AW-1:0] tbl [4];
      exp_ent_t      e;
      clear_stats();
      lat = 2;
      tbl[0] = 27'h7FFFFFE; tbl[1] = 27'h7FFFFFF; tbl[2] = 27'h0; tbl[3] = 27'h1;
      for (int unsigned i = 0; i < 4; i++) begin
         e.data = word_of(tbl[i]);
         e.eop  = (i == 3);
         exp_q.push_back(e);
         exp_addr_q.push_back(tbl[i]);
      end
      do_req(27'h7FFFFFE, 27'd4, 0);
      wait_done(100);
      check_cnt("wrap_dout", n_dout, 4);
      check_cnt("wrap_grants", n_grant, 4);
   endtask

   task automatic test_back_to_back();
      int unsigned n = 0;
      clear_stats();
      lat = 2;
      push_stream(27'h300, 3);
      do_req(27'h300, 27'd3, 0);
      while (dma_engineer_dout_eop !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_cnt("b2b_first_eop_seen", 32'(dma_engineer_dout_eop === 1'b1), 1);
      push_stream(27'h400, 2);
      do_req(27'h400, 27'd2, 1);
      wait_done(100);
      check_cnt("b2b_ack", n_ack, 2);
      check_cnt("b2b_dout", n_dout, 5);
      check_cnt("b2b_eop", n_eop, 2);
   endtask

   task automatic test_reset_mid();
      int unsigned n = 0;
      clear_stats();
      lat = 3;
      push_stream(27'h500, 10);
      do_req(27'h500, 27'd10, 0);
      while (n_dout < 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b0;
      #2;
      exp_q.delete();
      exp_addr_q.delete();
      @(negedge clk);
      checks++;
      if ({dma_engineer_ack, dma_engineer_dout_en, dma_engineer_dout_eop, mem_rd_req} !== 4'b0 ||
          dma_engineer_dout !== '0 || mem_rd_addr !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: ack/en/eop/req=%b addr=%h expected all 0",
                  {dma_engineer_ack, dma_engineer_dout_en, dma_engineer_dout_eop, mem_rd_req}, mem_rd_addr);
      end
      rst = 1'b1;
      n = 0;
      while (mem_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check_cnt("midreset_dout", n_dout, 3);
      check_cnt("midreset_no_eop", n_eop, 0);
      push_stream(27'h600, 2);
      do_req(27'h600, 27'd2, 0);
      wait_done(100);
      check_cnt("after_reset_dout", n_dout, 5);
      check_cnt("after_reset_eop", n_eop, 1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_outstanding();
      test_random_stalls();
      test_len0_len1();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
